execute_mc: RTL and testbench

//   Multi-cycle execute stage; parametrised successor of the single-cycle execute unit.

---
 rtl/execute_mc_if.sv | 34 +++
 rtl/execute_mc.sv | 174 +++++++++++++++++
 tb/tb_execute_mc.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/execute_mc_if.sv
// rtl/execute_mc_if.sv - decode/writeback/memory handshake bundle for execute_mc
interface execute_mc_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] op;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] rd;
  logic            is_jump;
  logic [XLEN-1:0] jump_dest;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  // master is the execute unit, slave is the surrounding pipeline/memory
  modport master (
    input  in_valid, op, pc, imm, rs1, rs2, out_ready, mem_ack, mem_rdata,
    output in_ready, out_valid, rd, is_jump, jump_dest, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output in_valid, op, pc, imm, rs1, rs2, out_ready, mem_ack, mem_rdata,
    input  in_ready, out_valid, rd, is_jump, jump_dest, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/execute_mc.sv
// rtl/execute_mc.sv - multi-cycle execute stage: 1-cycle ALU/branch, radix-2 MUL/DIV, req/ack LW/SW
module execute_mc #(
  parameter int XLEN    = 32,
  parameter int OP_W    = 5,
  parameter int PC_WORD = 1,
  parameter int DIV_EN  = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  execute_mc_if.master bus
);
  localparam int SH = $clog2(XLEN);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0),  OP_SUB  = OP_W'(1),  OP_AND = OP_W'(2),  OP_OR   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4),  OP_SLL  = OP_W'(5),  OP_SRL = OP_W'(6),  OP_SRA  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(8),  OP_SLTU = OP_W'(9),  OP_MUL = OP_W'(10), OP_MULHU = OP_W'(11);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(12), OP_DIVU = OP_W'(13), OP_REM = OP_W'(14), OP_REMU = OP_W'(15);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(16), OP_SW   = OP_W'(17), OP_JAL = OP_W'(18), OP_JALR = OP_W'(19);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(20), OP_BNE  = OP_W'(21), OP_BLT = OP_W'(22), OP_BGE  = OP_W'(23);

  typedef enum logic [2:0] {S_IDLE, S_ALU, S_ITER, S_MEM, S_DONE} state_t;

  state_t            state;
  logic [OP_W-1:0]   op_q;
  logic [XLEN-1:0]   pc_q, imm_q, a_q, b_q;
  logic [SH-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic              kill;

  logic              in_is_mul, in_is_div, in_div_special, iter_go;
  logic [XLEN-1:0]   off, np, tgt, alu_rd, alu_dest, iter_rd;
  logic              alu_jump, sgn;
  logic [XLEN-1:0]   a_abs, b_abs, r_new;
  logic [XLEN:0]     r_sh;
  logic              r_ge;
  logic [2*XLEN-1:0] mul_step, div_step, acc_n;

  // Division by zero and signed overflow bypass the iterator and resolve in the ALU path
  always_comb begin
    in_is_mul      = (bus.op == OP_MUL) || (bus.op == OP_MULHU);
    in_is_div      = (bus.op >= OP_DIV) && (bus.op <= OP_REMU);
    in_div_special = (bus.rs2 == '0) ||
                     (((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                      (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1));
    iter_go        = (DIV_EN != 0) && (in_is_mul || (in_is_div && !in_div_special));
  end

  always_comb begin
    off      = (PC_WORD != 0) ? XLEN'($signed(imm_q) >>> 2) : imm_q;
    np       = pc_q + ((PC_WORD != 0) ? XLEN'(1) : XLEN'(4));
    tgt      = pc_q + off;
    alu_rd   = '0;
    alu_jump = 1'b0;
    alu_dest = np;
    case (op_q)
      OP_ADD:  alu_rd = a_q + b_q;
      OP_SUB:  alu_rd = a_q - b_q;
      OP_AND:  alu_rd = a_q & b_q;
      OP_OR:   alu_rd = a_q | b_q;
      OP_XOR:  alu_rd = a_q ^ b_q;
      OP_SLL:  alu_rd = a_q << b_q[SH-1:0];
      OP_SRL:  alu_rd = a_q >> b_q[SH-1:0];
      OP_SRA:  alu_rd = XLEN'($signed(a_q) >>> b_q[SH-1:0]);
      OP_SLT:  alu_rd = XLEN'($signed(a_q) < $signed(b_q));
      OP_SLTU: alu_rd = XLEN'(a_q < b_q);
      OP_DIV, OP_DIVU: alu_rd = (DIV_EN == 0) ? '0 : ((b_q == '0) ? '1 : a_q);
      OP_REM, OP_REMU: alu_rd = (DIV_EN == 0) ? '0 : ((b_q == '0) ? a_q : '0);
      OP_JAL: begin
        alu_rd = np; alu_jump = 1'b1; alu_dest = tgt;
      end
      OP_JALR: begin
        alu_rd   = np; alu_jump = 1'b1;
        alu_dest = (a_q + off) & ~((PC_WORD != 0) ? XLEN'(0) : XLEN'(1));
      end
      OP_BEQ: begin alu_jump = (a_q == b_q);                   alu_dest = alu_jump ? tgt : np; end
      OP_BNE: begin alu_jump = (a_q != b_q);                   alu_dest = alu_jump ? tgt : np; end
      OP_BLT: begin alu_jump = ($signed(a_q) < $signed(b_q));  alu_dest = alu_jump ? tgt : np; end
      OP_BGE: begin alu_jump = ($signed(a_q) >= $signed(b_q)); alu_dest = alu_jump ? tgt : np; end
      default: ;
    endcase
  end

  // One iteration: MSB-first shift-add multiply, or restoring divide on magnitudes
  always_comb begin
    sgn      = (op_q == OP_DIV) || (op_q == OP_REM);
    a_abs    = (sgn && a_q[XLEN-1]) ? -a_q : a_q;
    b_abs    = (sgn && b_q[XLEN-1]) ? -b_q : b_q;
    mul_step = {acc[2*XLEN-2:0], 1'b0} + (b_q[cnt] ? {{XLEN{1'b0}}, a_q} : '0);
    r_sh     = {acc[2*XLEN-1:XLEN], a_abs[cnt]};
    r_ge     = r_sh >= {1'b0, b_abs};
    r_new    = r_ge ? (r_sh[XLEN-1:0] - b_abs) : r_sh[XLEN-1:0];
    div_step = {r_new, acc[XLEN-2:0], r_ge};
    acc_n    = ((op_q == OP_MUL) || (op_q == OP_MULHU)) ? mul_step : div_step;
    case (op_q)
      OP_MUL:          iter_rd = acc_n[XLEN-1:0];
      OP_MULHU:        iter_rd = acc_n[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: iter_rd = (sgn && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
      default:         iter_rd = (sgn && a_q[XLEN-1]) ? -acc_n[2*XLEN-1:XLEN] : acc_n[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.rd        <= '0;
      bus.is_jump   <= 1'b0;
      bus.jump_dest <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      op_q <= '0; pc_q <= '0; imm_q <= '0; a_q <= '0; b_q <= '0;
      cnt  <= '0; acc  <= '0; kill  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid && !flush) begin
          op_q <= bus.op; pc_q <= bus.pc; imm_q <= bus.imm; a_q <= bus.rs1; b_q <= bus.rs2;
          bus.in_ready <= 1'b0;
          kill         <= 1'b0;
          acc          <= '0;
          cnt          <= SH'(XLEN-1);
          if ((bus.op == OP_LW) || (bus.op == OP_SW)) begin
            state         <= S_MEM;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= (bus.op == OP_SW);
            bus.mem_addr  <= bus.rs1 + bus.imm;
            bus.mem_wdata <= bus.rs2;
          end else begin
            state <= iter_go ? S_ITER : S_ALU;
          end
        end
        S_ALU: if (flush) begin
          state <= S_IDLE; bus.in_ready <= 1'b1;
        end else begin
          bus.rd <= alu_rd; bus.is_jump <= alu_jump; bus.jump_dest <= alu_dest;
          bus.out_valid <= 1'b1; state <= S_DONE;
        end
        S_ITER: if (flush) begin
          state <= S_IDLE; bus.in_ready <= 1'b1;
        end else begin
          acc <= acc_n;
          if (cnt == '0) begin
            bus.rd <= iter_rd; bus.is_jump <= 1'b0; bus.jump_dest <= np;
            bus.out_valid <= 1'b1; state <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // A started memory access cannot be cancelled; a flush only discards its result
        S_MEM: begin
          if (flush) kill <= 1'b1;
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (kill || flush) begin
              state <= S_IDLE; bus.in_ready <= 1'b1;
            end else begin
              bus.rd <= bus.mem_we ? '0 : bus.mem_rdata;
              bus.is_jump <= 1'b0; bus.jump_dest <= np;
              bus.out_valid <= 1'b1; state <= S_DONE;
            end
          end
        end
        S_DONE: if (flush || bus.out_ready) begin
          bus.out_valid <= 1'b0; state <= S_IDLE; bus.in_ready <= 1'b1;
        end
        default: begin
          state <= S_IDLE; bus.in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_execute_mc.sv
// tb/tb_execute_mc.sv - directed self-checking bench for execute_mc
module tb_execute_mc;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   failures = 0;

  execute_mc_if #(.XLEN(32), .OP_W(5)) bus();

  execute_mc #(.XLEN(32), .OP_W(5), .PC_WORD(1), .DIV_EN(1)) dut (
    .clk  (clk),
    .rstn (rstn),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [4:0] o, input logic [31:0] p, input logic [31:0] i,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.op = o; bus.pc = p; bus.imm = i; bus.rs1 = a; bus.rs2 = b; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output logic ready_seen);
    lat = 0;
    ready_seen = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) ready_seen = 1'b1;
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic take(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] p,
                        input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_rd, input int exp_lat,
                        input logic exp_j, input logic [31:0] exp_dest);
    int   lat;
    logic rdy;
    issue(o, p, i, a, b);
    wait_result(lat, rdy);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(rdy), 32'd0);
    check({tag, "_rd"}, bus.rd, exp_rd);
    check({tag, "_jump"}, 32'(bus.is_jump), 32'(exp_j));
    check({tag, "_dest"}, bus.jump_dest, exp_dest);
    take(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    logic seen;
    bus.in_valid = 0; bus.op = 0; bus.pc = 0; bus.imm = 0; bus.rs1 = 0; bus.rs2 = 0;
    bus.out_ready = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_rd", bus.rd, 32'd0);
    check("rst_dest", bus.jump_dest, 32'd0);
    @(negedge clk) rstn = 1'b1;

    run_op("add",   5'd0,  0, 0, 32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 1,  0, 32'd1);
    run_op("sub",   5'd1,  0, 0, 32'd5,         32'd7,        32'hFFFF_FFFE, 1,  0, 32'd1);
    run_op("sra",   5'd7,  0, 0, 32'h8000_0000, 32'd4,        32'hF800_0000, 1,  0, 32'd1);
    run_op("srl",   5'd6,  0, 0, 32'h8000_0000, 32'h24,       32'h0800_0000, 1,  0, 32'd1);
    run_op("sll",   5'd5,  0, 0, 32'h0000_0003, 32'd31,       32'h8000_0000, 1,  0, 32'd1);
    run_op("xor",   5'd4,  0, 0, 32'hF0F0_1234, 32'h0FF0_00FF,32'hFF00_12CB, 1,  0, 32'd1);
    run_op("slt",   5'd8,  0, 0, 32'hFFFF_FFFF, 32'd1,        32'd1,         1,  0, 32'd1);
    run_op("sltu",  5'd9,  0, 0, 32'hFFFF_FFFF, 32'd1,        32'd0,         1,  0, 32'd1);
    run_op("mul",   5'd10, 0, 0, 32'h0001_0000, 32'h0001_0000,32'd0,         32, 0, 32'd1);
    run_op("mulhu", 5'd11, 0, 0, 32'h0001_0000, 32'h0001_0000,32'd1,         32, 0, 32'd1);
    run_op("mul3",  5'd10, 0, 0, 32'hFFFF_FFFF, 32'd3,        32'hFFFF_FFFD, 32, 0, 32'd1);
    run_op("mulhu3",5'd11, 0, 0, 32'hFFFF_FFFF, 32'd3,        32'd2,         32, 0, 32'd1);
    run_op("div0",  5'd12, 0, 0, 32'd7,         32'd0,        32'hFFFF_FFFF, 1,  0, 32'd1);
    run_op("remu0", 5'd15, 0, 0, 32'd5,         32'd0,        32'd5,         1,  0, 32'd1);
    run_op("removf",5'd14, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF,32'd0,         1,  0, 32'd1);
    run_op("divovf",5'd12, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF,32'h8000_0000, 1,  0, 32'd1);
    run_op("divu",  5'd13, 0, 0, 32'd100,       32'd7,        32'd14,        32, 0, 32'd1);
    run_op("remu",  5'd15, 0, 0, 32'd100,       32'd7,        32'd2,         32, 0, 32'd1);
    run_op("divneg",5'd12, 0, 0, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32, 0, 32'd1);
    run_op("remneg",5'd14, 0, 0, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32, 0, 32'd1);
    run_op("beq",   5'd20, 32'h10, 32'h20, 32'd5, 32'd5,      32'd0,         1,  1, 32'h18);
    run_op("bne",   5'd21, 32'h10, 32'h20, 32'd5, 32'd5,      32'd0,         1,  0, 32'h11);
    run_op("blt",   5'd22, 32'h10, 32'h20, 32'hFFFF_FFFF, 32'd1, 32'd0,      1,  1, 32'h18);
    run_op("bge",   5'd23, 32'h10, 32'h20, 32'hFFFF_FFFF, 32'd1, 32'd0,      1,  0, 32'h11);
    run_op("jal",   5'd18, 32'h10, 32'h20, 32'd0, 32'd0,      32'h11,        1,  1, 32'h18);
    run_op("jalr",  5'd19, 32'h10, 32'hFFFF_FFF8, 32'h100, 32'd0, 32'h11,    1,  1, 32'hFE);

    issue(5'd16, 32'h20, 32'd4, 32'h1000, 32'd0);
    check("lw_addr", bus.mem_addr, 32'h1004);
    check("lw_we", 32'(bus.mem_we), 32'd0);
    cyc = bus.mem_req ? 1 : 0;
    repeat (3) begin
      @(posedge clk);
      #1 if (bus.mem_req) cyc++;
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    check("lw_req_cycles", 32'(cyc), 32'd4);
    check("lw_req_drop", 32'(bus.mem_req), 32'd0);
    check("lw_valid", 32'(bus.out_valid), 32'd1);
    check("lw_rd", bus.rd, 32'hDEAD_BEEF);
    check("lw_dest", bus.jump_dest, 32'h21);
    repeat (2) @(posedge clk);
    #1;
    check("lw_hold_valid", 32'(bus.out_valid), 32'd1);
    check("lw_hold_rd", bus.rd, 32'hDEAD_BEEF);
    take("lw");

    issue(5'd17, 32'd0, 32'd8, 32'h200, 32'hCAFE_F00D);
    check("sw_req", 32'(bus.mem_req), 32'd1);
    check("sw_we", 32'(bus.mem_we), 32'd1);
    check("sw_addr", bus.mem_addr, 32'h208);
    check("sw_wdata", bus.mem_wdata, 32'hCAFE_F00D);
    bus.mem_ack = 1'b1;
    @(posedge clk);
    #1 bus.mem_ack = 1'b0;
    check("sw_valid", 32'(bus.out_valid), 32'd1);
    check("sw_rd", bus.rd, 32'd0);
    check("sw_req_drop", 32'(bus.mem_req), 32'd0);
    take("sw");

    issue(5'd10, 32'd0, 32'd0, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_ready", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bus.out_valid) seen = 1'b1;
    end
    check("flush_no_valid", 32'(seen), 32'd0);

    @(negedge clk);
    bus.op = 5'd0; bus.rs1 = 32'd1; bus.rs2 = 32'd1; bus.in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0; flush = 1'b0;
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1 check("flush_in_no_valid", 32'(bus.out_valid), 32'd0);

    issue(5'd16, 32'd0, 32'd0, 32'h40, 32'd0);
    check("rst_lw_req", 32'(bus.mem_req), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_req", 32'(bus.mem_req), 32'd0);
    check("rst_mid_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mid_addr", bus.mem_addr, 32'd0);
    @(negedge clk) rstn = 1'b1;
    run_op("add_post", 5'd0, 32'h5, 0, 32'd2, 32'd3, 32'd5, 1, 0, 32'h6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
